// File: rtl/viterbi_acs_sched.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_acs_sched
//  Purpose  : Schedules one shared ACS unit over the four trellis states per
//             received symbol, with path-metric commit and normalization.
//  Revision : 1.0  initial release
// ============================================================================
module viterbi_acs_sched #(
    parameter int PM_W    = 7,
    parameter int NORM_TH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sym_valid,
    input  logic [1:0]      sym_data,
    input  logic            frame_start,
    output logic            sym_ready,
    output logic [1:0]      acs_self_state,
    output logic [1:0]      acs_data_recv,
    output logic [1:0]      acs_addr_in_1,
    output logic [1:0]      acs_addr_in_2,
    output logic            acs_term_1,
    output logic            acs_term_2,
    output logic [PM_W-1:0] acs_pm_in1,
    output logic [PM_W-1:0] acs_pm_in2,
    input  logic [PM_W-1:0] acs_pm_out,
    input  logic [1:0]      acs_addr_out,
    input  logic            acs_term_out,
    input  logic            acs_dec_out,
    output logic            step_valid,
    output logic [3:0]      dec_bits,
    output logic [7:0]      surv_addr,
    output logic [1:0]      best_state,
    output logic            err_all_term
);

    localparam logic [PM_W-1:0] c_pm_term  = '1;
    localparam logic [PM_W-1:0] c_pm_clamp = c_pm_term - PM_W'(2);
    localparam logic [PM_W-1:0] c_norm_th  = PM_W'(NORM_TH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_S0     = 3'd1,
        ST_S1     = 3'd2,
        ST_S2     = 3'd3,
        ST_S3     = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sym;
    logic [PM_W-1:0] r_pm [0:3];
    logic [3:0]      r_term;
    logic [PM_W-1:0] r_sh_pm [0:3];
    logic [3:0]      r_sh_term;
    logic [3:0]      r_sh_dec;
    logic [7:0]      r_sh_addr;
    logic            r_step_valid;
    logic [3:0]      r_dec_bits;
    logic [7:0]      r_surv_addr;
    logic [1:0]      r_best_state;
    logic            r_err_all_term;

    logic            w_active;
    logic [1:0]      w_k;
    logic [1:0]      w_addr1;
    logic [1:0]      w_addr2;
    logic [PM_W-1:0] w_sh_pm_new;
    logic [PM_W-1:0] w_min;
    logic [1:0]      w_best;
    logic            w_all_term;
    logic            w_norm;

    always_comb begin
        w_active = 1'b1;
        w_k      = 2'd0;
        case (r_state)
            ST_S0:   w_k = 2'd0;
            ST_S1:   w_k = 2'd1;
            ST_S2:   w_k = 2'd2;
            ST_S3:   w_k = 2'd3;
            default: w_active = 1'b0;
        endcase
    end

    // Both predecessors of state k share its low bit as their high bit.
    assign w_addr1 = {w_k[0], 1'b0};
    assign w_addr2 = {w_k[0], 1'b1};

    assign acs_self_state = w_active ? w_k           : 2'd0;
    assign acs_data_recv  = w_active ? r_sym         : 2'd0;
    assign acs_addr_in_1  = w_active ? w_addr1       : 2'd0;
    assign acs_addr_in_2  = w_active ? w_addr2       : 2'd0;
    assign acs_term_1     = w_active ? r_term[w_addr1] : 1'b0;
    assign acs_term_2     = w_active ? r_term[w_addr2] : 1'b0;
    assign acs_pm_in1     = w_active ? r_pm[w_addr1] : '0;
    assign acs_pm_in2     = w_active ? r_pm[w_addr2] : '0;

    // Live metrics never reach the terminated marker value.
    assign w_sh_pm_new = acs_term_out ? c_pm_term :
                         ((acs_pm_out > c_pm_clamp) ? c_pm_clamp : acs_pm_out);

    always_comb begin
        w_min  = c_pm_term;
        w_best = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_sh_term[i] && (r_sh_pm[i] < w_min)) begin
                w_min  = r_sh_pm[i];
                w_best = 2'(i);
            end
        end
    end

    assign w_all_term = &r_sh_term;
    assign w_norm     = !w_all_term && (w_min >= c_norm_th);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_sym          <= 2'd0;
            r_pm[0]        <= '0;
            r_pm[1]        <= c_pm_term;
            r_pm[2]        <= c_pm_term;
            r_pm[3]        <= c_pm_term;
            r_term         <= 4'b1110;
            for (int i = 0; i < 4; i++) begin
                r_sh_pm[i] <= '0;
            end
            r_sh_term      <= 4'd0;
            r_sh_dec       <= 4'd0;
            r_sh_addr      <= 8'd0;
            r_step_valid   <= 1'b0;
            r_dec_bits     <= 4'd0;
            r_surv_addr    <= 8'd0;
            r_best_state   <= 2'd0;
            r_err_all_term <= 1'b0;
        end else begin
            r_step_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        r_sym <= sym_data;
                        if (frame_start) begin
                            r_pm[0] <= '0;
                            r_pm[1] <= c_pm_term;
                            r_pm[2] <= c_pm_term;
                            r_pm[3] <= c_pm_term;
                            r_term  <= 4'b1110;
                        end
                        r_state <= ST_S0;
                    end
                end
                ST_S0, ST_S1, ST_S2, ST_S3: begin
                    r_sh_pm[w_k]             <= w_sh_pm_new;
                    r_sh_term[w_k]           <= acs_term_out;
                    r_sh_dec[w_k]            <= acs_dec_out;
                    r_sh_addr[{w_k, 1'b0} +: 2] <= acs_addr_out;
                    r_state <= (r_state == ST_S3) ? ST_COMMIT : state_t'(r_state + 3'd1);
                end
                ST_COMMIT: begin
                    if (w_all_term) begin
                        r_err_all_term <= 1'b1;
                        r_pm[0]        <= '0;
                        r_pm[1]        <= c_pm_term;
                        r_pm[2]        <= c_pm_term;
                        r_pm[3]        <= c_pm_term;
                        r_term         <= 4'b1110;
                        r_best_state   <= 2'd0;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r_pm[i] <= (w_norm && !r_sh_term[i]) ? (r_sh_pm[i] - c_norm_th)
                                                                 : r_sh_pm[i];
                        end
                        r_term       <= r_sh_term;
                        r_best_state <= w_best;
                    end
                    r_dec_bits   <= r_sh_dec;
                    r_surv_addr  <= r_sh_addr;
                    r_step_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sym_ready    = (r_state == ST_IDLE);
    assign step_valid   = r_step_valid;
    assign dec_bits     = r_dec_bits;
    assign surv_addr    = r_surv_addr;
    assign best_state   = r_best_state;
    assign err_all_term = r_err_all_term;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_acs_sched
//  Purpose  : Self-checking bench: attached ACS model plus trellis-step model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_viterbi_acs_sched;

    typedef struct packed {
        logic [6:0] pm;
        logic [1:0] addr;
        logic       term;
        logic       dec;
    } acs_r_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sym_valid, frame_start, sym_ready;
    logic [1:0] sym_data;
    logic [1:0] acs_self_state, acs_data_recv, acs_addr_in_1, acs_addr_in_2;
    logic       acs_term_1, acs_term_2;
    logic [6:0] acs_pm_in1, acs_pm_in2, acs_pm_out;
    logic [1:0] acs_addr_out;
    logic       acs_term_out, acs_dec_out;
    logic       step_valid, err_all_term;
    logic [3:0] dec_bits;
    logic [7:0] surv_addr;
    logic [1:0] best_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    bit prev_hold = 0;
    int g_mode = 0;   // 0 normal ACS, 1 all terminated, 2 metric bias
    int g_bias = 0;

    int         mpm [4];
    bit         mterm [4];
    bit         merr;
    logic [3:0] edec;
    logic [7:0] esurv;
    logic [1:0] ebest;

    acs_r_t acs_res;

    viterbi_acs_sched #(.PM_W(7), .NORM_TH(32)) dut (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
        .frame_start(frame_start), .sym_ready(sym_ready),
        .acs_self_state(acs_self_state), .acs_data_recv(acs_data_recv),
        .acs_addr_in_1(acs_addr_in_1), .acs_addr_in_2(acs_addr_in_2),
        .acs_term_1(acs_term_1), .acs_term_2(acs_term_2),
        .acs_pm_in1(acs_pm_in1), .acs_pm_in2(acs_pm_in2),
        .acs_pm_out(acs_pm_out), .acs_addr_out(acs_addr_out),
        .acs_term_out(acs_term_out), .acs_dec_out(acs_dec_out),
        .step_valid(step_valid), .dec_bits(dec_bits), .surv_addr(surv_addr),
        .best_state(best_state), .err_all_term(err_all_term)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog expired");
    end

    // Rate-1/2 code: new state = {u, p[1]}, outputs {u^p1^p0, u^p0}.
    function automatic int bmf(input logic [1:0] p, input logic u, input logic [1:0] sym);
        logic c1, c0;
        c1 = u ^ p[1] ^ p[0];
        c0 = u ^ p[0];
        return int'(sym[1] != c1) + int'(sym[0] != c0);
    endfunction

    function automatic acs_r_t acs_fn(input logic [1:0] k, input logic [1:0] p1,
                                      input logic [1:0] p2, input logic [1:0] sym,
                                      input logic [6:0] pm1, input logic t1,
                                      input logic [6:0] pm2, input logic t2,
                                      input int mode, input int bias);
        acs_r_t r;
        int m1, m2;
        r.addr = p1; r.dec = 1'b0; r.term = 1'b1; r.pm = 7'd0;
        if (mode == 1) return r;
        if (t1 && t2) begin r.pm = 7'd127; return r; end
        m1 = t1 ? 1000 : int'(pm1) + bmf(p1, k[1], sym);
        m2 = t2 ? 1000 : int'(pm2) + bmf(p2, k[1], sym);
        r.term = 1'b0;
        if (m2 < m1) begin r.addr = p2; r.dec = 1'b1; m1 = m2; end
        m1 = m1 + bias;
        if (m1 > 127) m1 = 127;
        r.pm = 7'(m1);
        return r;
    endfunction

    always_comb begin
        acs_res = acs_fn(acs_self_state, acs_addr_in_1, acs_addr_in_2, acs_data_recv,
                         acs_pm_in1, acs_term_1, acs_pm_in2, acs_term_2, g_mode, g_bias);
    end
    assign acs_pm_out   = acs_res.pm;
    assign acs_addr_out = acs_res.addr;
    assign acs_term_out = acs_res.term;
    assign acs_dec_out  = acs_res.dec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_init();
        mpm   = '{0, 127, 127, 127};
        mterm = '{0, 1, 1, 1};
    endtask

    task automatic run_step(input logic [1:0] sym, input bit fs, input bit hold);
        acs_r_t     r [4];
        logic [1:0] p1, p2, kk;
        int         wn, mn;
        bit         allt;
        wn = 0;
        while (sym_ready !== 1'b1 && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        chk("ready_wait", sym_ready, 1);
        sym_valid = 1'b1; sym_data = sym; frame_start = fs;
        @(posedge clk);
        #1;
        if (hold && prev_hold) chk("b2b_gap", cyc - last_acc, 6);
        last_acc = cyc;
        if (fs) model_init();
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            p1 = {kk[0], 1'b0};
            p2 = {kk[0], 1'b1};
            r[k] = acs_fn(kk, p1, p2, sym, 7'(mpm[p1]), mterm[p1], 7'(mpm[p2]), mterm[p2],
                          g_mode, g_bias);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) begin
                sym_valid = 1'b0;
                frame_start = 1'($urandom_range(0, 1));
                sym_data = 2'($urandom);
            end
            kk = 2'(k);
            p1 = {kk[0], 1'b0};
            p2 = {kk[0], 1'b1};
            chk("acs_self", acs_self_state, kk);
            chk("acs_addr1", acs_addr_in_1, p1);
            chk("acs_addr2", acs_addr_in_2, p2);
            chk("acs_data", acs_data_recv, sym);
            chk("acs_pm1", acs_pm_in1, mpm[p1]);
            chk("acs_pm2", acs_pm_in2, mpm[p2]);
            chk("acs_t1", acs_term_1, mterm[p1]);
            chk("acs_t2", acs_term_2, mterm[p2]);
            chk("busy_ready", sym_ready, 0);
            chk("busy_sv", step_valid, 0);
        end
        @(negedge clk);
        chk("commit_sv", step_valid, 0);
        chk("commit_ready", sym_ready, 0);
        chk("commit_acs", {acs_self_state, acs_pm_in1, acs_term_1}, 0);
        allt = 1;
        for (int k = 0; k < 4; k++) begin
            if (!r[k].term) allt = 0;
            edec[k] = r[k].dec;
            esurv[2*k +: 2] = r[k].addr;
        end
        if (allt) begin
            merr = 1;
            model_init();
            ebest = 2'd0;
        end else begin
            mn = 1000;
            ebest = 2'd0;
            for (int k = 0; k < 4; k++) begin
                mterm[k] = r[k].term;
                mpm[k] = r[k].term ? 127 : ((r[k].pm > 7'd125) ? 125 : int'(r[k].pm));
            end
            for (int k = 0; k < 4; k++)
                if (!mterm[k] && mpm[k] < mn) begin mn = mpm[k]; ebest = 2'(k); end
            if (mn >= 32)
                for (int k = 0; k < 4; k++)
                    if (!mterm[k]) mpm[k] = mpm[k] - 32;
        end
        @(negedge clk);
        chk("step_valid", step_valid, 1);
        chk("idle_ready", sym_ready, 1);
        chk("dec_bits", dec_bits, edec);
        chk("surv_addr", surv_addr, esurv);
        chk("best_state", best_state, ebest);
        chk("err_all_term", err_all_term, merr);
        prev_hold = hold;
    endtask

    initial begin
        int sv_seen;
        rst_n = 1'b0; sym_valid = 1'b0; sym_data = 2'd0; frame_start = 1'b0;
        model_init(); merr = 0;
        repeat (3) @(negedge clk);
        chk("rst_sv", step_valid, 0);
        chk("rst_dec", dec_bits, 0);
        chk("rst_surv", surv_addr, 0);
        chk("rst_best", best_state, 0);
        chk("rst_err", err_all_term, 0);
        chk("rst_acs", {acs_self_state, acs_data_recv, acs_addr_in_1, acs_addr_in_2,
                        acs_term_1, acs_term_2, acs_pm_in1, acs_pm_in2}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", sym_ready, 1);

        // First step after reset on symbol 00.
        run_step(2'b00, 0, 0);
        chk("fresh00_best", best_state, 0);
        chk("fresh00_surv", surv_addr, 8'h88);
        chk("fresh00_dec", dec_bits, 0);

        for (int i = 0; i < 10; i++) run_step(2'($urandom), 0, 0);

        // frame_start restarts the trellis: same as a fresh run on 11.
        run_step(2'b11, 1, 0);
        chk("frame11_best", best_state, 2);
        chk("frame11_surv", surv_addr, 8'h88);

        // Back-to-back symbols with sym_valid held high.
        for (int i = 0; i < 4; i++) run_step(2'($urandom), 0, 1);
        sym_valid = 1'b0;
        prev_hold = 0;

        // Large metrics drive saturation and normalization.
        g_mode = 2; g_bias = 40;
        for (int i = 0; i < 6; i++) run_step(2'($urandom), 0, 0);
        g_mode = 0; g_bias = 0;
        for (int i = 0; i < 3; i++) run_step(2'($urandom), 0, 0);

        // Every state terminated: sticky error and bank re-initialisation.
        g_mode = 1;
        run_step(2'($urandom), 0, 0);
        chk("allterm_err", err_all_term, 1);
        chk("allterm_best", best_state, 0);
        g_mode = 0;
        for (int i = 0; i < 2; i++) run_step(2'($urandom), 0, 0);
        chk("err_sticky", err_all_term, 1);

        // Reset asserted in S2 discards the step.
        @(negedge clk);
        sym_valid = 1'b1; sym_data = 2'b01; frame_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sym_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midrst_in_s2", acs_self_state, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_acs", {acs_self_state, acs_data_recv, acs_addr_in_1, acs_addr_in_2,
                           acs_term_1, acs_term_2, acs_pm_in1, acs_pm_in2}, 0);
        chk("midrst_sv", step_valid, 0);
        chk("midrst_err", err_all_term, 0);
        chk("midrst_out", {dec_bits, surv_addr, best_state}, 0);
        model_init(); merr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (step_valid !== 1'b0) sv_seen++;
        end
        chk("midrst_no_pulse", sv_seen, 0);
        chk("midrst_ready", sym_ready, 1);
        run_step(2'b00, 0, 0);
        chk("post_rst_best", best_state, 0);
        chk("post_rst_surv", surv_addr, 8'h88);

        for (int i = 0; i < 8; i++) run_step(2'($urandom), 1'($urandom_range(0, 3) == 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/viterbi_acs_sched.md
VITERBI_ACS_SCHED -- requirements
Module: viterbi_acs_sched

Interface
REQ-001 SHALL have parameter PM_W, default 7, path-metric width; only value 7 is supported.
REQ-002 SHALL have parameter NORM_TH, default 32, normalization threshold and subtrahend.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 sym_valid  input  1  received 2-bit symbol present.
REQ-007 sym_data  input  2  received code symbol.
REQ-008 frame_start  input  1  sampled with an accepted symbol; re-initialises metrics first.
REQ-009 sym_ready  output  1  controller can accept a symbol.
REQ-010 acs_self_state  output  2  state index driven to the shared combinational ACS unit.
REQ-011 acs_data_recv  output  2  latched symbol driven to the ACS unit.
REQ-012 acs_addr_in_1, acs_addr_in_2  output  2 each  predecessor state indices.
REQ-013 acs_term_1, acs_term_2  output  1 each  predecessor-terminated flags.
REQ-014 acs_pm_in1, acs_pm_in2  output  7 each  predecessor path metrics.
REQ-015 acs_pm_out  input  7  ACS survivor metric.
REQ-016 acs_addr_out  input  2  ACS survivor predecessor.
REQ-017 acs_term_out  input  1  ACS terminated flag.
REQ-018 acs_dec_out  input  1  ACS decision bit.
REQ-019 step_valid  output  1  one-cycle pulse; trellis step results valid.
REQ-020 dec_bits  output  4  acs_dec_out per state, bit i = state i.
REQ-021 surv_addr  output  8  survivor predecessor per state, bits [2i+1:2i] = state i.
REQ-022 best_state  output  2  lowest-metric non-terminated state.
REQ-023 err_all_term  output  1  sticky: all four states terminated.

Function
REQ-024 FSM states SHALL be IDLE, S0, S1, S2, S3, COMMIT; sym_ready=1 only in IDLE.
REQ-025 Handshake: a symbol is accepted at the rising edge where sym_valid&sym_ready=1; sym_data is latched; IDLE->S0.
REQ-026 Transitions SHALL be S0->S1->S2->S3->COMMIT->IDLE, one cycle each; there are no stalls; throughput is one symbol per 6 cycles.
REQ-027 In Sk: acs_self_state=k, acs_addr_in_1={k[0],0}, acs_addr_in_2={k[0],1}.
REQ-028 In Sk: acs_term_1/2 and acs_pm_in1/2 SHALL come from the committed term/PM bank at those addresses; acs_data_recv = the latched symbol.
REQ-029 ACS outputs SHALL be captured into a shadow bank at the end of each Sk.
REQ-030 When acs_term_out=1, the shadow SHALL store PM=127 and term=1.
REQ-031 When acs_term_out=0, the shadow SHALL store min(acs_pm_out,125) and term=0.
REQ-032 Outside S0-S3, all acs_* outputs SHALL be 0.
REQ-033 COMMIT: copy shadow to the committed bank.
REQ-034 COMMIT normalization: if the min PM over non-terminated states >= NORM_TH, subtract NORM_TH from every non-terminated PM in the same commit.
REQ-035 At the end of COMMIT, register dec_bits, surv_addr and best_state, and assert step_valid for exactly the next cycle, which coincides with the return to IDLE.
REQ-036 best_state tie-break: lowest index; terminated states are excluded.
REQ-037 All four shadow terms =1 at COMMIT: set err_all_term, re-initialise the bank per REQ-039, best_state=0.
REQ-038 frame_start=1 on an accepted symbol: the bank is re-initialised before S0 uses it (same acceptance edge).
REQ-039 Re-initialisation: PM={0,127,127,127}, term={0,1,1,1}.
REQ-040 frame_start without acceptance SHALL be ignored.

Reset
REQ-041 rst_n=0 SHALL asynchronously force IDLE and sym_ready=1 (after release).
REQ-042 rst_n=0 SHALL clear step_valid, dec_bits, surv_addr, best_state, err_all_term and all acs_* outputs to 0.
REQ-043 rst_n=0 SHALL load the bank per REQ-039 and clear the shadow bank and latched symbol.
REQ-044 Reset asserted mid-step SHALL discard the step and produce no step_valid pulse.

Verification
REQ-045 Reset, then sym 00 at T, ACS model attached: S0-S3 in T+1..T+4; step_valid at T+6; PM={0,127,2,127}; term={0,1,0,1}; best_state=0; surv_addr[1:0]=00.
REQ-046 Back-to-back sym_valid held high: acceptances exactly 6 cycles apart; sym_ready low for 5 cycles after each.
REQ-047 Force all committed PMs to >= 32 with no terms: after COMMIT each PM is reduced by 32; best_state unchanged.
REQ-048 Preload all term=1: err_all_term=1 after COMMIT; bank = init values; err_all_term stays 1 until reset.
REQ-049 Assert rst_n low in S2: outputs 0 immediately; no step_valid; next symbol produces the same result as REQ-045.
REQ-050 frame_start=1 with sym 11 after 10 random steps: result equals a fresh-reset run on sym 11.
